// File: rtl/text_pkg.sv
// Shared constants and types for the text-mode character RAM writer.
package text_pkg;

  localparam int DEF_COLS   = 80;
  localparam int DEF_ROWS   = 30;
  localparam int DEF_ADDR_W = $clog2(DEF_COLS * DEF_ROWS);

  localparam int COL_W = 7;
  localparam int ROW_W = 5;
  localparam int CNT_W = 12;

  localparam logic [7:0] SPACE     = 8'h20;
  localparam logic [7:0] NEWLINE   = 8'h0A;
  localparam logic [7:0] BACKSPACE = 8'h08;
  localparam logic [7:0] PRINT_MIN = 8'h20;
  localparam logic [7:0] PRINT_MAX = 8'h7E;

  typedef enum logic {CLEAR, RUN} state_t;

  typedef enum logic [2:0] {
    CUR_HOLD,
    CUR_ADV,
    CUR_NL,
    CUR_BS,
    CUR_HOME
  } cur_cmd_t;

  function automatic logic is_print(input logic [7:0] c);
    return (c >= PRINT_MIN) && (c <= PRINT_MAX);
  endfunction

endpackage

// File: rtl/text_cursor.sv
// Cursor over the COLS x ROWS grid; applies one movement command per cycle
// and exposes the next position plus linear RAM addresses.
module text_cursor
  import text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  cur_cmd_t          cmd,
  output logic [COL_W-1:0]  col,
  output logic [ROW_W-1:0]  row,
  output logic [COL_W-1:0]  nxt_col,
  output logic [ROW_W-1:0]  nxt_row,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] bs_addr,
  output logic              at_origin
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic [COL_W-1:0] back_col;
  logic [ROW_W-1:0] back_row;
  logic [ROW_W-1:0] row_inc;

  function automatic logic [ADDR_W-1:0] lin(input logic [ROW_W-1:0] r,
                                            input logic [COL_W-1:0] c);
    return ADDR_W'(r) * ADDR_W'(COLS) + ADDR_W'(c);
  endfunction

  assign at_origin = (col == '0) && (row == '0);
  assign addr      = lin(row, col);
  // Backspace target depends only on the current position, not on cmd,
  // so the top can pick the write address without a combinational loop.
  assign bs_addr   = lin(back_row, back_col);

  always_comb begin
    row_inc = (row == ROW_LAST) ? '0 : row + 1'b1;
    if (col != '0) begin
      back_col = col - 1'b1;
      back_row = row;
    end else if (row != '0) begin
      back_col = COL_LAST;
      back_row = row - 1'b1;
    end else begin
      back_col = '0;
      back_row = '0;
    end
  end

  always_comb begin
    nxt_col = col;
    nxt_row = row;
    case (cmd)
      CUR_ADV: begin
        if (col == COL_LAST) begin
          nxt_col = '0;
          nxt_row = row_inc;
        end else begin
          nxt_col = col + 1'b1;
        end
      end
      CUR_NL: begin
        nxt_col = '0;
        nxt_row = row_inc;
      end
      CUR_BS: begin
        nxt_col = back_col;
        nxt_row = back_row;
      end
      CUR_HOME: begin
        nxt_col = '0;
        nxt_row = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col <= '0;
      row <= '0;
    end else begin
      col <= nxt_col;
      row <= nxt_row;
    end
  end

endmodule

// File: rtl/ascii_text_writer.sv
// Streams ASCII bytes into the text-mode character RAM, handling newline,
// backspace and a full-screen blanking sequence after reset or on request.
module ascii_text_writer
  import text_pkg::*;
#(
  parameter int COLS   = DEF_COLS,
  parameter int ROWS   = DEF_ROWS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_char,
  output logic              in_ready,
  input  logic              clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [COL_W-1:0]  cursor_col,
  output logic [ROW_W-1:0]  cursor_row,
  output logic [CNT_W-1:0]  char_count,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(COLS * ROWS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              wr_en_nxt;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [7:0]        wr_data_nxt;
  logic [CNT_W-1:0]  cnt_nxt;
  cur_cmd_t          cmd;

  logic [COL_W-1:0]  nxt_col;
  logic [ROW_W-1:0]  nxt_row;
  logic [ADDR_W-1:0] cur_addr, bs_addr;
  logic              at_origin;

  assign in_ready = (state == RUN) && !clear;
  assign busy     = (state == CLEAR);

  text_cursor #(
    .COLS   (COLS),
    .ROWS   (ROWS),
    .ADDR_W (ADDR_W)
  ) u_cursor (
    .clk       (clk),
    .reset     (reset),
    .cmd       (cmd),
    .col       (cursor_col),
    .row       (cursor_row),
    .nxt_col   (nxt_col),
    .nxt_row   (nxt_row),
    .addr      (cur_addr),
    .bs_addr   (bs_addr),
    .at_origin (at_origin)
  );

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr;
    wr_data_nxt = wr_data;
    cnt_nxt     = char_count;
    cmd         = CUR_HOLD;
    case (state)
      CLEAR: begin
        // clear is deliberately ignored here: the sweep never restarts.
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = idx;
        wr_data_nxt = SPACE;
        if (idx == CLR_LAST) begin
          state_nxt = RUN;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          cmd       = CUR_HOME;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      RUN: begin
        if (clear) begin
          state_nxt = CLEAR;
          idx_nxt   = '0;
        end else if (in_valid) begin
          if (is_print(in_char)) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = cur_addr;
            wr_data_nxt = in_char;
            cnt_nxt     = (char_count == '1) ? char_count : char_count + 1'b1;
            cmd         = CUR_ADV;
          end else if (in_char == NEWLINE) begin
            cmd = CUR_NL;
          end else if (in_char == BACKSPACE && !at_origin) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = bs_addr;
            wr_data_nxt = SPACE;
            cmd         = CUR_BS;
          end
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      char_count <= '0;
    end else begin
      idx        <= idx_nxt;
      wr_en      <= wr_en_nxt;
      wr_addr    <= wr_addr_nxt;
      wr_data    <= wr_data_nxt;
      char_count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_ascii_text_writer.sv
// Bench for ascii_text_writer: directed steps plus random bytes checked
// against a linear-position screen model.
module tb_ascii_text_writer;

  localparam int NC = 80;
  localparam int NR = 30;
  localparam int NCELL = NC * NR;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_char = 8'h00;
  logic        in_ready;
  logic        clear = 1'b0;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic [11:0] char_count;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;
  int pos    = 0;   // model cursor as linear cell index
  int cnt    = 0;

  always #5 clk = ~clk;

  ascii_text_writer dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_char    (in_char),
    .in_ready   (in_ready),
    .clear      (clear),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row),
    .char_count (char_count),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_col"}, 32'(cursor_col), pos % NC);
    chk({tag, "_row"}, 32'(cursor_row), pos / NC);
    chk({tag, "_cnt"}, 32'(char_count), cnt);
  endtask

  task automatic blank_run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("clr_we", 32'(wr_en), 1);
      chk("clr_addr", 32'(wr_addr), i);
      chk("clr_data", 32'(wr_data), 32'h20);
      chk("clr_busy", 32'(busy), (i < NCELL - 1) ? 1 : 0);
    end
    if (n == NCELL) begin
      pos = 0;
      cnt = 0;
      chk("post_ready", 32'(in_ready), 1);
      chk_cursor("post_clr");
    end
  endtask

  task automatic send(input logic [7:0] ch);
    bit we;
    int ea;
    logic [7:0] ed;
    we = 0; ea = 0; ed = 8'h00;
    chk("pre_ready", 32'(in_ready), 1);
    in_valid = 1'b1;
    in_char  = ch;
    tick();
    in_valid = 1'b0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      we = 1; ea = pos; ed = ch;
      pos = (pos + 1) % NCELL;
      cnt = (cnt < 4095) ? cnt + 1 : 4095;
    end else if (ch == 8'h0A) begin
      pos = ((pos / NC + 1) % NR) * NC;
    end else if (ch == 8'h08 && pos > 0) begin
      pos = pos - 1;
      we = 1; ea = pos; ed = 8'h20;
    end
    chk("we", 32'(wr_en), 32'(we));
    if (we) begin
      chk("addr", 32'(wr_addr), ea);
      chk("data", 32'(wr_data), 32'(ed));
    end
    chk_cursor("send");
  endtask

  task automatic rnd_byte(output logic [7:0] b);
    int r;
    r = $urandom_range(0, 9);
    if (r <= 5)      b = 8'($urandom_range(32, 126));
    else if (r == 6) b = 8'h0A;
    else if (r == 7) b = 8'h08;
    else if (r == 8) begin
      b = 8'($urandom_range(0, 31));
      if (b == 8'h08 || b == 8'h0A) b = 8'h1B;
    end else         b = 8'($urandom_range(127, 255));
  endtask

  initial begin
    logic [7:0] b;

    // reset state
    tick();
    chk("rst_we", 32'(wr_en), 0);
    chk("rst_addr", 32'(wr_addr), 0);
    chk("rst_data", 32'(wr_data), 0);
    chk("rst_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 1);
    chk_cursor("rst");
    reset = 1'b0;
    blank_run(NCELL);

    // generator pattern a..z
    for (int c = 8'h61; c <= 8'h7A; c++) send(8'(c));
    chk("az_col", 32'(cursor_col), 26);
    chk("az_cnt", 32'(char_count), 26);

    // clear beats a simultaneous byte
    clear = 1'b1; in_valid = 1'b1; in_char = 8'h41;
    #1;
    chk("clr_req_ready", 32'(in_ready), 0);
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_req_we", 32'(wr_en), 0);
    chk("clr_req_busy", 32'(busy), 1);
    chk_cursor("clr_req");
    blank_run(NCELL);

    // row wrap of the cursor and row-end column wrap
    for (int i = 0; i < NC; i++) send(8'h41);
    send(8'h42);
    chk("b_col", 32'(cursor_col), 1);
    chk("b_row", 32'(cursor_row), 1);
    for (int i = 0; i < NR - 2; i++) send(8'h0A);
    chk("nl_row29", 32'(cursor_row), 29);
    send(8'h0A);
    chk("nl_wrap", 32'(cursor_row), 0);

    // backspace across a row boundary, at origin, and a dropped control
    send(8'h0A);
    send(8'h08);
    chk("bs_col", 32'(cursor_col), 79);
    chk("bs_row", 32'(cursor_row), 0);
    for (int i = 0; i < NC - 1; i++) send(8'h08);
    send(8'h08);
    chk("bs_org_we", 32'(wr_en), 0);
    send(8'h07);
    chk("bel_we", 32'(wr_en), 0);

    // random mixed traffic
    for (int i = 0; i < 400; i++) begin
      rnd_byte(b);
      send(b);
    end

    // saturate char_count
    for (int i = 0; i < 4200; i++) send(8'($urandom_range(32, 126)));
    chk("sat_cnt", 32'(char_count), 4095);

    // async reset in the middle of a clear sweep
    clear = 1'b1;
    tick();
    clear = 1'b0;
    blank_run(1000);
    reset = 1'b1;
    #1;
    chk("mid_we", 32'(wr_en), 0);
    chk("mid_addr", 32'(wr_addr), 0);
    chk("mid_data", 32'(wr_data), 0);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_ready", 32'(in_ready), 0);
    pos = 0; cnt = 0;
    chk_cursor("mid");
    tick();
    tick();
    reset = 1'b0;
    blank_run(NCELL);
    send(8'h5A);
    send(8'h0A);
    send(8'h31);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_text_writer.md
# ascii_text_writer

Consumes a stream of ASCII bytes from the character generator stage and writes them into the text-mode character RAM that the VGA text renderer reads. Maintains a cursor over a COLS×ROWS grid and interprets newline and backspace. Provides a full-screen clear sequence. Sits directly downstream of the ASCII generator and directly upstream of the character RAM write port.

## Interface
- COLS, 80, characters per row (≤128)
- ROWS, 30, rows per screen (≤32)
- ADDR_W, $clog2(COLS*ROWS) = 12, character RAM address width
- clk  in  1  system clock; all logic on posedge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  in_char holds a byte to consume
- in_char  in  8  ASCII byte
- in_ready  out  1  block accepts in_char this cycle
- clear  in  1  single-cycle request to blank screen
- wr_en  out  1  character RAM write strobe
- wr_addr  out  ADDR_W  RAM address = row*COLS + col
- wr_data  out  8  byte to write
- cursor_col  out  7  current column
- cursor_row  out  5  current row
- char_count  out  12  printable characters written since last clear; saturates at 4095
- busy  out  1  high while CLEAR runs

## Operation
- FSM states: CLEAR, RUN.
- Reset: state=CLEAR, clear index=0, cursor (0,0), char_count=0, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, busy=1.
- Acceptance: byte consumed on posedge where in_valid && in_ready. in_ready = (state==RUN) && !clear.
- CLEAR: each cycle writes 0x20 to address idx, idx=0..COLS*ROWS-1. After the last write: cursor (0,0), char_count=0, go to RUN. clear asserted during CLEAR is ignored (no restart).
- RUN, clear asserted: enter CLEAR with idx=0. Takes priority over a simultaneous in_valid; that byte is not consumed.
- RUN, printable byte 0x20–0x7E: write byte at cursor, char_count+1 (saturating), col+1.
  - At col=COLS-1: col=0, row+1.
- 0x0A (newline): no write; col=0, row+1.
- 0x08 (backspace):
  - col>0: col-1, write 0x20 at new position.
  - col=0, row>0: row-1, col=COLS-1, write 0x20 there.
  - At (0,0): no-op, no write.
  - char_count unchanged in all cases.
- All other bytes (0x00–0x1F except 0x08/0x0A, 0x7F–0xFF): consumed and dropped; no write, no cursor change.
- Row wrap: row+1 from ROWS-1 goes to 0. No scrolling; old text is overwritten.
- Address arithmetic: row*COLS + col computed at ADDR_W bits. No overflow is possible for legal cursor values.

## Timing
- Throughput: one byte per cycle in RUN; no bubbles.
- Latency: byte accepted at edge N gives wr_en/wr_addr/wr_data valid after edge N and sampled by RAM at edge N+1. Cursor outputs update at edge N.
- wr_en is high for exactly one cycle per write and is low whenever no write occurs.
- CLEAR duration: COLS*ROWS cycles of wr_en=1 (2400 by default).
  - in_ready and busy change on the edge that leaves CLEAR.
  - First byte can be accepted on the following edge.
- Reset asserted mid-CLEAR or mid-stream: outputs return to reset values immediately (asynchronously), then a full CLEAR restarts.

## Structure
- Shared package text_pkg holds:
  - COLS, ROWS, ADDR_W defaults
  - ASCII constants: SPACE=8'h20, NEWLINE=8'h0A, BACKSPACE=8'h08, PRINT_MIN=8'h20, PRINT_MAX=8'h7E
  - state enum {CLEAR, RUN}
- One sub-module, text_cursor: holds col/row and takes advance/newline/backspace commands. It outputs the next col/row and the linear address.
- The top level holds the FSM, clear index, char_count and output registers.

## Test plan
- Reset, then hold in_valid=0 → 2400 writes of 0x20 at addresses 0..2399. Then busy=0, in_ready=1, cursor (0,0).
- Feed 0x61..0x7A back-to-back (generator pattern) → wr_addr 0..25, wr_data 0x61..0x7A, cursor_col=26, char_count=26.
- Write 80 × 0x41 then 0x42 → 0x42 at addr 80; cursor (1,1). Then 0x0A at row 29 → cursor row 0.
- Cursor (0,1), send 0x08 → write 0x20 at addr 79, cursor (79,0). Send 0x08 at (0,0) → no wr_en, cursor unchanged. Send 0x07 → no write.
- clear and in_valid(0x41) in the same cycle → 0x41 not consumed, in_ready=0. 2400 blank writes follow, then char_count=0.
- Assert reset mid-CLEAR at idx=1000 → wr_en=0 immediately. After release, clear restarts at addr 0.
